// File: rtl/base_system_poller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : base_system_poller_pkg
//  Description : Shared types and widths for the DIP-switch poller slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package base_system_poller_pkg;

    // Avalon-MM word address width and switch bank width
    localparam int c_addr_w = 2;
    localparam int c_sw_w   = 8;

    // Poll transaction states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_LAT  = 2'd2,
        ST_EVAL = 2'd3
    } poll_state_e;

endpackage
`default_nettype wire

// File: rtl/base_system_sample_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : base_system_sample_debounce
//  Description : Accepts a new switch value once it has been sampled
//                DEBOUNCE_COUNT times in a row; pulses changed on update.
//  Revision    : 1.0 - initial release
// ============================================================================
module base_system_sample_debounce
    import base_system_poller_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [c_sw_w-1:0] sample,
    input  logic              sample_valid,
    output logic [c_sw_w-1:0] value,
    output logic              changed
);

    localparam logic [3:0] c_deb = 4'(DEBOUNCE_COUNT);

    logic [c_sw_w-1:0] r_candidate;
    logic [c_sw_w-1:0] r_value;
    logic [3:0]        r_stable_cnt;
    logic              r_changed;

    logic [c_sw_w-1:0] w_candidate_nxt;
    logic [3:0]        w_stable_nxt;
    logic              w_update;

    // Next candidate / run length for the incoming sample, and whether it commits
    always_comb begin
        w_candidate_nxt = r_candidate;
        w_stable_nxt    = r_stable_cnt;
        if (sample == r_candidate) begin
            if (r_stable_cnt < c_deb) begin
                w_stable_nxt = r_stable_cnt + 4'd1;
            end
        end else begin
            w_candidate_nxt = sample;
            w_stable_nxt    = 4'd1;
        end
        w_update = (w_stable_nxt == c_deb) && (w_candidate_nxt != r_value);
    end

    // Debounce state; changed is a single-cycle pulse aligned with the value update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_candidate  <= '0;
            r_stable_cnt <= '0;
            r_value      <= '0;
            r_changed    <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (sample_valid) begin
                r_candidate  <= w_candidate_nxt;
                r_stable_cnt <= w_stable_nxt;
                if (w_update) begin
                    r_value   <= w_candidate_nxt;
                    r_changed <= 1'b1;
                end
            end
        end
    end

    assign value   = r_value;
    assign changed = r_changed;

endmodule
`default_nettype wire

// File: rtl/base_system_dipsw_poller.sv
`default_nettype none
// ============================================================================
//  Module      : base_system_dipsw_poller
//  Description : Periodically reads a DIP-switch register over Avalon-MM and
//                publishes a debounced 8-bit value with a change pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module base_system_dipsw_poller
    import base_system_poller_pkg::*;
#(
    parameter int POLL_PERIOD    = 1000,
    parameter int DEBOUNCE_COUNT = 4,
    parameter int READ_LATENCY   = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    output logic [c_addr_w-1:0] avm_address,
    output logic                avm_read,
    input  logic                avm_waitrequest,
    input  logic [31:0]         avm_readdata,
    output logic [c_sw_w-1:0]   value,
    output logic                changed
);

    localparam int                 c_timer_w    = $clog2(POLL_PERIOD);
    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(POLL_PERIOD - 1);
    localparam logic [1:0]         c_lat        = 2'(READ_LATENCY);

    poll_state_e        r_state;
    poll_state_e        w_state_nxt;
    logic [c_timer_w-1:0] r_timer;
    logic [1:0]         r_lat_cnt;
    logic [c_sw_w-1:0]  r_sample;
    logic               w_tick;
    logic               w_accept;
    logic               w_sample_valid;
    logic               w_unused_upper;

    assign w_tick         = enable && (r_timer == c_timer_last);
    assign w_accept       = (r_state == ST_READ) && !avm_waitrequest;
    assign w_sample_valid = (r_state == ST_EVAL);
    assign w_unused_upper = ^avm_readdata[31:c_sw_w];
    assign avm_address    = '0;

    // Free-running poll timer; cleared and frozen while polling is disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (!enable || (r_timer == c_timer_last)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and read strobe; ticks seen outside IDLE are simply ignored
    always_comb begin
        w_state_nxt = r_state;
        avm_read    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    w_state_nxt = ST_LAT;
                end
            end
            ST_LAT: begin
                if (r_lat_cnt == 2'd1) begin
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latency countdown; sample is captured on the cycle the count reaches one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lat_cnt <= '0;
            r_sample  <= '0;
        end else if (w_accept) begin
            r_lat_cnt <= c_lat;
        end else if (r_state == ST_LAT) begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
            if (r_lat_cnt == 2'd1) begin
                r_sample <= avm_readdata[c_sw_w-1:0];
            end
        end
    end

    base_system_sample_debounce #(
        .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
    ) u_debounce (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample       (r_sample),
        .sample_valid (w_sample_valid),
        .value        (value),
        .changed      (changed)
    );

endmodule
`default_nettype wire

// File: tb/tb_base_system_dipsw_poller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_base_system_dipsw_poller
//  Description : Directed self-checking bench. Instance A uses period 8,
//                debounce 3, latency 1; instance B uses period 8, debounce 1,
//                latency 3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_base_system_dipsw_poller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b1;
    logic        enable_a = 1'b0, wr_a = 1'b0;
    logic [31:0] rd_a = '0;
    logic [1:0]  addr_a;
    logic        read_a, changed_a;
    logic [7:0]  value_a;
    logic        enable_b = 1'b0, wr_b = 1'b0;
    logic [31:0] rd_b = '0;
    logic [1:0]  addr_b;
    logic        read_b, changed_b;
    logic [7:0]  value_b;

    base_system_dipsw_poller #(.POLL_PERIOD(8), .DEBOUNCE_COUNT(3), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable_a), .avm_address(addr_a),
        .avm_read(read_a), .avm_waitrequest(wr_a), .avm_readdata(rd_a),
        .value(value_a), .changed(changed_a));

    base_system_dipsw_poller #(.POLL_PERIOD(8), .DEBOUNCE_COUNT(1), .READ_LATENCY(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable_b), .avm_address(addr_b),
        .avm_read(read_b), .avm_waitrequest(wr_b), .avm_readdata(rd_b),
        .value(value_b), .changed(changed_b));

    int cyc = 0, acc_a = 0, acc_cyc_a = 0, acc_prev_a = 0, chg_a = 0, acc_b = 0, chg_b = 0;
    int n_pass = 0, n_total = 0;

    // Event monitors: accepted reads and change pulses, with cycle stamps
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (read_a && !wr_a) begin
            acc_a      <= acc_a + 1;
            acc_prev_a <= acc_cyc_a;
            acc_cyc_a  <= cyc;
        end
        if (changed_a) chg_a <= chg_a + 1;
        if (read_b && !wr_b) acc_b <= acc_b + 1;
        if (changed_b) chg_b <= chg_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_acc_a(input int target, input string tag);
        int n = 0;
        while (acc_a < target && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(acc_a >= target), 32'd1);
    endtask

    task automatic wait_read(input bit use_b, input string tag);
        int n = 0;
        while (!(use_b ? read_b : read_a) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(use_b ? read_b : read_a), 32'd1);
    endtask

    // One B transaction: readdata walks p1..p4 in the cycles after accept
    task automatic poll_b(input logic [7:0] p1, input logic [7:0] p2,
                          input logic [7:0] p3, input logic [7:0] p4);
        wait_read(1'b1, "b_read_timeout");
        rd_b = 32'h66;
        @(negedge clk); rd_b = {24'h0, p1};
        @(negedge clk); rd_b = {24'h0, p2};
        @(negedge clk); rd_b = {24'h0, p3};
        @(negedge clk); rd_b = {24'h0, p4};
        @(negedge clk); rd_b = 32'h77;
        @(negedge clk);
    endtask

    int en_cyc, base_acc, base_chg, t0;
    logic held;

    initial begin
        // Reset state
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_value", 32'(value_a), 32'h0);
        check("rst_changed", 32'(changed_a), 32'h0);
        check("rst_read", 32'(read_a), 32'h0);
        check("rst_address", 32'(addr_a), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Stable 0xA5: three reads 8 cycles apart, one change after the third
        rd_a = 32'h0000_00A5;
        enable_a = 1'b1;
        en_cyc = cyc;
        base_acc = acc_a;
        wait_acc_a(base_acc + 1, "a5_read1_timeout");
        check("first_poll_cycle", 32'(acc_cyc_a - en_cyc), 32'd8);
        wait_acc_a(base_acc + 3, "a5_read3_timeout");
        check("poll_interval", 32'(acc_cyc_a - acc_prev_a), 32'd8);
        check("a5_before_commit", 32'(value_a), 32'h0);
        repeat (4) @(negedge clk);
        check("a5_value", 32'(value_a), 32'hA5);
        check("a5_pulses", 32'(chg_a), 32'd1);

        // Alternating 0x01 / 0x02 never settles
        reset_n = 1'b0;
        enable_a = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        base_acc = acc_a;
        base_chg = chg_a;
        enable_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd_a = (i % 2 == 0) ? 32'h1 : 32'h2;
            wait_acc_a(base_acc + i + 1, "toggle_timeout");
            repeat (2) @(negedge clk);
        end
        check("toggle_value", 32'(value_a), 32'h0);
        check("toggle_pulses", 32'(chg_a - base_chg), 32'd0);

        // Upper readdata bits are ignored
        rd_a = 32'hFFFF_FF00;
        for (int i = 0; i < 4; i++) begin
            wait_acc_a(base_acc + 7 + i, "upper_timeout");
            repeat (2) @(negedge clk);
        end
        check("upper_value", 32'(value_a), 32'h0);
        check("upper_pulses", 32'(chg_a - base_chg), 32'd0);

        // 12-cycle stall: read held, overlapping tick dropped, one sample
        rd_a = 32'h3C;
        wr_a = 1'b1;
        wait_read(1'b0, "stall_read_timeout");
        t0 = acc_a;
        held = 1'b1;
        for (int i = 0; i < 12; i++) begin
            held &= read_a;
            @(negedge clk);
        end
        held &= read_a;
        wr_a = 1'b0;
        check("stall_read_held", 32'(held), 32'd1);
        repeat (3) @(negedge clk);
        check("stall_accepts", 32'(acc_a - t0), 32'd1);
        wait_acc_a(t0 + 2, "stall_next_timeout");
        repeat (3) @(negedge clk);
        check("stall_one_sample", 32'(value_a), 32'h0);
        wait_acc_a(t0 + 3, "stall_third_timeout");
        repeat (4) @(negedge clk);
        check("stall_value", 32'(value_a), 32'h3C);
        check("stall_pulses", 32'(chg_a - base_chg), 32'd1);

        // Latency 3 capture point, debounce 1 updates on every new value
        enable_b = 1'b1;
        base_chg = chg_b;
        poll_b(8'h11, 8'h22, 8'h33, 8'h44);
        check("lat3_first", 32'(value_b), 32'h33);
        poll_b(8'h21, 8'h32, 8'h43, 8'h54);
        check("lat3_second", 32'(value_b), 32'h43);
        check("lat3_pulses", 32'(chg_b - base_chg), 32'd2);

        // Reset while B is in its latency window
        rd_b = 32'h99;
        wait_read(1'b1, "rst_lat_read_timeout");
        @(negedge clk);
        base_acc = acc_b;
        base_chg = chg_b;
        reset_n = 1'b0;
        #1;
        check("async_value_a", 32'(value_a), 32'h0);
        check("async_value_b", 32'(value_b), 32'h0);
        check("async_read_b", 32'(read_b), 32'h0);
        check("async_changed", 32'({changed_a, changed_b}), 32'h0);
        enable_a = 1'b0;
        enable_b = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abandon_value", 32'(value_b), 32'h0);
        check("abandon_pulses", 32'(chg_b - base_chg), 32'd0);
        check("abandon_reads", 32'(acc_b - base_acc), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/base_system_dipsw_poller.md
BASE_SYSTEM_DIPSW_POLLER -- requirements
Module: base_system_dipsw_poller

Interface
REQ-001 SHALL provide parameter POLL_PERIOD, default 1000, meaning clocks between poll launches (minimum 4).
REQ-002 SHALL provide parameter DEBOUNCE_COUNT, default 4, meaning consecutive identical samples required to accept a new value (range 1..15).
REQ-003 SHALL provide parameter READ_LATENCY, default 1, meaning fixed clocks from read accept to valid avm_readdata (range 1..3).
REQ-004 SHALL provide port clk  in  1  single system clock; all logic rising-edge.
REQ-005 SHALL provide port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL provide port enable  in  1  polling enabled when high.
REQ-007 SHALL provide port avm_address  out  2  Avalon-MM word address; always 0.
REQ-008 SHALL provide port avm_read  out  1  Avalon-MM read request.
REQ-009 SHALL provide port avm_waitrequest  in  1  slave stall; read is accepted in the cycle it is low with avm_read high.
REQ-010 SHALL provide port avm_readdata  in  32  registered slave read data.
REQ-011 SHALL provide port value  out  8  last debounced switch value.
REQ-012 SHALL provide port changed  out  1  one-cycle pulse when value updates.

Function
REQ-013 SHALL run a poll timer 0..POLL_PERIOD-1 while enable=1, wrapping to 0; tick = timer at POLL_PERIOD-1.
REQ-014 SHALL implement states IDLE, READ, LAT, and EVAL.
REQ-015 IDLE: on tick, SHALL go to READ; a tick arriving outside IDLE SHALL be dropped, not queued.
REQ-016 READ: SHALL hold avm_read=1 and avm_address=0 while waitrequest=1; on accept, SHALL go to LAT and load the latency counter with READ_LATENCY.
REQ-017 LAT: SHALL decrement the counter and capture avm_readdata[7:0] exactly READ_LATENCY cycles after the accept cycle, then go to EVAL.
REQ-018 avm_readdata[31:8] SHALL be ignored.
REQ-019 EVAL: if sample equals candidate, stable_cnt SHALL increment, saturating at DEBOUNCE_COUNT; otherwise candidate SHALL take the sample and stable_cnt SHALL be set to 1.
REQ-020 EVAL: when the resulting stable_cnt equals DEBOUNCE_COUNT and candidate differs from value, value SHALL take candidate on the next edge and changed SHALL be high for exactly that cycle; the state SHALL then return to IDLE.
REQ-021 A candidate equal to value SHALL produce no changed pulse.
REQ-022 With DEBOUNCE_COUNT=1, every sample differing from value SHALL update it.
REQ-023 enable falling mid-transaction SHALL let the current read complete through EVAL; the timer SHALL clear to 0 and hold while enable=0.
REQ-024 avm_read SHALL never be asserted outside READ and SHALL never be withdrawn before accept.
REQ-025 Polls SHALL be non-overlapping: at most one outstanding read.

Reset
REQ-026 Assertion of reset_n SHALL asynchronously force state IDLE, timer 0, latency counter 0, candidate 0, stable_cnt 0, value 0, changed 0, avm_read 0, and avm_address 0.
REQ-027 Reset SHALL abandon any in-flight read with no completion.
REQ-028 The first tick after reset SHALL occur POLL_PERIOD cycles after enable is first sampled high.

Structure
REQ-029 The shared package base_system_poller_pkg SHALL hold the state enumeration, the 2-bit address width constant, and the 8-bit switch width constant.
REQ-030 Debounce (candidate, stable_cnt, value, changed) SHALL be a sub-module base_system_sample_debounce with a sample/sample_valid input.

Verification (POLL_PERIOD=8, DEBOUNCE_COUNT=3, READ_LATENCY=1 unless stated)
REQ-031 Bench SHALL drive switches 0xA5 with enable=1 and waitrequest=0 -> reads every 8 cycles; value=0xA5 and a single changed pulse after the 3rd read.
REQ-032 Bench SHALL toggle switches 0x01/0x02 on alternate polls -> value stays 0x00 and changed never asserts.
REQ-033 Bench SHALL hold waitrequest high for 12 cycles on one read -> avm_read stays high throughout, the intervening tick is dropped, and exactly one sample is taken.
REQ-034 Bench SHALL set READ_LATENCY=3 and change readdata each cycle after accept -> the captured sample is the word present 3 cycles after accept.
REQ-035 Bench SHALL assert reset_n low during LAT -> all outputs are 0 immediately; after release, no capture occurs from the abandoned read.
REQ-036 Bench SHALL drive upper readdata bits 0xFFFFFF00 with lower 0x00 -> value stays 0x00.
